// File: rtl/blink_meter.sv
// blink_meter: receives an external square wave, synchronises and glitch-filters
// it, measures each half-period in clock cycles and reports lock when
// consecutive half-periods agree within TOL. LEDG shows lock and filtered level.
module blink_meter #(
    parameter int CNT_W   = 32,
    parameter int FILTER  = 16,
    parameter int TOL     = 1000,
    parameter int TIMEOUT = 100000000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             blink_in,
    output logic [CNT_W-1:0] half_period,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost,
    output logic [1:0]       LEDG
);

    localparam int FC_W = (FILTER < 2) ? 1 : $clog2(FILTER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_TRACK
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_f;
    logic [FC_W-1:0]  r_fc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_prev;
    logic [CNT_W-1:0] r_half_period;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_lost;
    state_t           r_state;

    logic             w_e;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_diff;
    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_prev_next;
    logic [CNT_W-1:0] w_half_period_next;
    logic             w_meas_valid_next;
    logic             w_locked_next;
    logic             w_lost_next;

    // Two-flop synchroniser for the asynchronous input.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= blink_in;
            r_sync2 <= r_sync1;
        end
    end

    // Edge event: the filter has seen FILTER consecutive disagreeing samples.
    always_comb begin
        w_e = (r_sync2 != r_f) && (r_fc == FC_W'(FILTER - 1));
    end

    // Glitch filter: toggle the filtered level only after a long enough disagreement.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_f  <= 1'b0;
            r_fc <= '0;
        end else if (r_sync2 == r_f) begin
            r_fc <= '0;
        end else if (w_e) begin
            r_f  <= ~r_f;
            r_fc <= '0;
        end else begin
            r_fc <= r_fc + FC_W'(1);
        end
    end

    // Saturating increment and unsigned magnitude difference against the previous measurement.
    always_comb begin
        w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
        w_diff    = (r_cnt >= r_prev) ? (r_cnt - r_prev) : (r_prev - r_cnt);
    end

    // Measurement FSM next-state and next-output logic; an edge beats a coincident timeout.
    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_prev_next        = r_prev;
        w_half_period_next = r_half_period;
        w_meas_valid_next  = 1'b0;
        w_locked_next      = r_locked;
        w_lost_next        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_e) begin
                    w_state_next = S_ARMED;
                    w_cnt_next   = CNT_W'(1);
                end
            end
            S_ARMED, S_TRACK: begin
                if (w_e) begin
                    w_state_next       = S_TRACK;
                    w_cnt_next         = CNT_W'(1);
                    w_half_period_next = r_cnt;
                    w_prev_next        = r_cnt;
                    w_meas_valid_next  = 1'b1;
                    if (r_state == S_TRACK) begin
                        w_locked_next = (w_diff <= CNT_W'(TOL));
                    end
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_state_next  = S_IDLE;
                    w_cnt_next    = '0;
                    w_locked_next = 1'b0;
                    w_lost_next   = 1'b1;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Measurement FSM state and registered outputs.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_prev        <= '0;
            r_half_period <= '0;
            r_meas_valid  <= 1'b0;
            r_locked      <= 1'b0;
            r_lost        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_prev        <= w_prev_next;
            r_half_period <= w_half_period_next;
            r_meas_valid  <= w_meas_valid_next;
            r_locked      <= w_locked_next;
            r_lost        <= w_lost_next;
        end
    end

    // Output mapping; LEDG is a direct view of the registered lock and filtered level.
    always_comb begin
        half_period = r_half_period;
        meas_valid  = r_meas_valid;
        locked      = r_locked;
        lost        = r_lost;
        LEDG        = {r_f, r_locked};
    end

endmodule

// File: tb/tb_blink_meter.sv
// Directed bench for blink_meter: expected measurements are queued as the
// input is toggled and compared whenever the DUT pulses meas_valid.
module tb_blink_meter;

    localparam int CNT_W   = 32;
    localparam int FILTER  = 4;
    localparam int TOL     = 10;
    localparam int TIMEOUT = 5000;

    logic             clk;
    logic             reset;
    logic             blink_in;
    logic [CNT_W-1:0] half_period;
    logic             meas_valid;
    logic             locked;
    logic             lost;
    logic [1:0]       LEDG;

    typedef struct {
        int   hp;
        logic lk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lost_cnt = 0;
    int   exp_lost = 0;
    int   lost_cyc = 0;
    int   last_meas_cyc = 0;

    blink_meter #(
        .CNT_W  (CNT_W),
        .FILTER (FILTER),
        .TOL    (TOL),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .blink_in   (blink_in),
        .half_period(half_period),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lost       (lost),
        .LEDG       (LEDG)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait n cycles, confirm the filtered level has settled to the input, then toggle.
    task automatic tog(input int n, input bit push, input int hp, input logic lk);
        repeat (n) @(negedge clk);
        if (n >= 10) check("ledg1_level", 64'(LEDG[1]), 64'(blink_in));
        blink_in = ~blink_in;
        if (push) exp_q.push_back('{hp: hp, lk: lk});
    endtask

    // Scoreboard monitor: pop an expectation for every measurement, count lost pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (meas_valid) begin
                exp_t e;
                last_meas_cyc = cyc;
                check("meas_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("half_period", 64'(half_period), 64'(e.hp));
                    check("locked", 64'(locked), 64'(e.lk));
                    $display("meas: half_period=%0d locked=%0d", half_period, locked);
                end
            end
            if (lost) begin
                lost_cnt++;
                lost_cyc = cyc;
                $display("lost pulse at cycle %0d", cyc);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        blink_in = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_half_period", 64'(half_period), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_meas_valid", 64'(meas_valid), 64'd0);
        check("rst_lost", 64'(lost), 64'd0);
        check("rst_ledg", 64'(LEDG), 64'd0);
        reset = 1'b0;

        // Steady 1000-cycle toggles: first edge arms, lock from the third edge.
        tog(100, 0, 0, 0);
        tog(1000, 1, 1000, 0);
        tog(1000, 1, 1000, 1);
        tog(1000, 1, 1000, 1);
        tog(1000, 1, 1000, 1);
        tog(1000, 1, 1000, 1);

        // Out-of-tolerance half-period drops lock; a repeat re-locks.
        tog(1050, 1, 1050, 0);
        tog(1050, 1, 1050, 1);
        tog(1000, 1, 1000, 0);
        tog(1000, 1, 1000, 1);

        // Short glitches are filtered; a 4-cycle pulse yields two edges 4 apart.
        tog(1000, 0, 0, 0);
        tog(3, 0, 0, 0);
        tog(1000, 0, 0, 0);
        tog(3, 0, 0, 0);
        tog(1000, 1, 3006, 0);
        tog(4, 1, 4, 0);
        tog(1000, 1, 1000, 0);
        tog(1000, 1, 1000, 1);

        // Hold input: one lost pulse TIMEOUT cycles after the last edge.
        exp_lost = 1;
        repeat (6000) @(negedge clk);
        check("lost_count", 64'(lost_cnt), 64'(exp_lost));
        check("lost_delay", 64'(lost_cyc - last_meas_cyc), 64'(TIMEOUT));
        check("lost_locked", 64'(locked), 64'd0);
        check("lost_half_period", 64'(half_period), 64'd1000);

        // Resume: three edges needed to lock again.
        tog(100, 0, 0, 0);
        tog(1000, 1, 1000, 0);
        tog(1000, 1, 1000, 1);
        tog(1000, 1, 1000, 1);

        // One-cycle reset while locked clears outputs before the next clock edge.
        repeat (50) @(negedge clk);
        check("pre_rst_locked", 64'(locked), 64'd1);
        reset = 1'b1;
        #1;
        check("async_half_period", 64'(half_period), 64'd0);
        check("async_locked", 64'(locked), 64'd0);
        check("async_ledg", 64'(LEDG), 64'd0);
        check("async_meas_valid", 64'(meas_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        tog(100, 0, 0, 0);
        tog(1000, 1, 1000, 0);

        // Edge coincident with the timeout: measurement wins, no lost, stays tracking.
        tog(5000, 1, 5000, 0);
        tog(5000, 1, 5000, 1);
        repeat (200) @(negedge clk);
        check("final_lost_count", 64'(lost_cnt), 64'(exp_lost));
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
